ann_param_memory: RTL and testbench
===================================

Name: ann_param_memory

Overview:
- Dual-port parameter/activation store for the fixed 3-layer MLP (input -> hidden1 -> hidden2 -> output).
- Holds one data bank (per-layer node activations) and one weight bank (per-layer weights including bias).
- Serves the feed-forward, back-propagation and weight-update engines through two independent request ports: data and weight.
- Each request port echoes layer/address alongside read results.

Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single bit pattern, stored opaquely).
- LAYER_WIDTH, 2, layer selector width.
- NUMBER_OF_INPUT_NODE, 2, input nodes (IN).
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden-1 nodes (H1).
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden-2 nodes (H2).
- NUMBER_OF_OUTPUT_NODE, 3, output nodes (OUT).
- Derived: DATA_COUNTER_WIDTH = clog2(H1).
- Derived: WEIGHT_COUNTER_WIDTH = 11.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- i_ram_data_enable  in  1  data-port request strobe.
- i_rw_data_select  in  1  1 = read, 0 = write.
- i_data_layer  in  LAYER_WIDTH  data layer: 0 input, 1 hidden1, 2 hidden2, 3 output.
- i_data_addr  in  DATA_COUNTER_WIDTH  node index within layer.
- i_data  in  DATA_WIDTH  write data.
- i_ram_weight_enable  in  1  weight-port request strobe.
- i_rw_weight_select  in  1  1 = read, 0 = write.
- i_weight_layer  in  LAYER_WIDTH  weight layer: 1 = in->h1, 2 = h1->h2, 3 = h2->out.
- i_weight_addr  in  11  flat index within layer.
- i_weight  in  DATA_WIDTH  write weight.
- o_data_valid  out  1  data read result valid.
- o_data_layer  out  LAYER_WIDTH  echoed layer.
- o_data_addr  out  DATA_COUNTER_WIDTH  echoed address.
- o_data  out  DATA_WIDTH  read data.
- o_weight_valid  out  1  weight read result valid.
- o_weight_layer  out  LAYER_WIDTH  echoed layer.
- o_weight_addr  out  11  echoed address.
- o_weight  out  DATA_WIDTH  read weight.

Behaviour:
- Data bank depth per layer: IN, H1, H2, OUT.
- Weight bank depth per layer:
  - Layer 1: H1*(IN+1) = 96.
  - Layer 2: H2*(H1+1) = 1056.
  - Layer 3: OUT*(H2+1) = 99.
  - Weight layer 0 has no storage.
- Implementation choice is free: separate arrays or one flat RAM with a per-layer base offset.
- Write (enable=1, select=0): stores the word at the rising edge; no output strobe.
- Read (enable=1, select=1): exactly 1-cycle latency.
  - Next cycle: o_*_valid=1, with layer/addr echoed and the stored word on the data output.
- Enable=0: o_*_valid=0 next cycle; other outputs hold their last value.
- Back-to-back reads every cycle give one result per cycle, in order.
- Data port and weight port are fully independent and may be active in the same cycle.
- Read of an address written in the same cycle returns the OLD contents (read-before-write).
  - Cannot occur on a single port, since one op per port per cycle.
- Out-of-range access (addr >= layer depth, or weight layer 0):
  - Write is ignored.
  - Read still returns valid=1 with echoed layer/addr and data = 0.
- Reset (rst_n=0 at the clock edge):
  - All o_* outputs are cleared to 0.
  - Bank contents are retained, not cleared.
  - Requests presented during reset are ignored.
- Reset mid-read: a result due on the reset edge is discarded (valid=0).
- Power-up contents are undefined until written; the bench loads weights before reading.

Optional Feature:
- Macro ANN_MEM_WRITE_ACK_EN.
- When defined: each write also produces, 1 cycle later, o_*_valid=1 with echoed layer/addr and the written word on o_data / o_weight.
  - Lets an upstream loader confirm stores.
  - Ignored out-of-range writes echo data 0.
- When undefined: writes produce no output strobe (default).

Test Plan:
- Write weight layer 1 addr 0..95 with value 0x3F800000+addr, then read addr 0..95 back-to-back -> 96 consecutive valid results, each one cycle after its request, correct echo and data.
- Write weight layer 2 addr 1055 = 0x40490FDB and layer 3 addr 98 = 0xBF000000, then read both -> exact values; reading layer 3 addr 99 -> valid=1, data 0.
- Write data layer 3 addr 2 = 0x41200000 while the same cycle reads weight layer 1 addr 5 -> weight result next cycle unaffected; a later data read of layer 3 addr 2 returns 0x41200000.
- Write data layer 1 addr 7 = A, then write B while reading addr 7 on the next request -> returns B (write committed); a write to weight layer 0 -> ignored, reads 0.
- Issue a read, then assert rst_n=0 at the next edge -> o_weight_valid=0 and all outputs 0; after release, reading the same address returns pre-reset contents.
- With ANN_MEM_WRITE_ACK_EN defined: write weight layer 1 addr 3 = 0x12345678 -> next cycle o_weight_valid=1, o_weight_addr=3, o_weight=0x12345678; undefined -> no strobe.

Source files
------------

// File: rtl/ann_param_memory_if.sv
// Request/response bundle for ann_param_memory: a data port and a weight port,
// each with a request side (i_*) and an echoed read-result side (o_*).
interface ann_param_memory_if #(
  parameter int unsigned DATA_WIDTH           = 32,
  parameter int unsigned LAYER_WIDTH          = 2,
  parameter int unsigned DATA_COUNTER_WIDTH   = 5,
  parameter int unsigned WEIGHT_COUNTER_WIDTH = 11
);

  // data port request
  logic                            i_ram_data_enable;
  logic                            i_rw_data_select;
  logic [LAYER_WIDTH-1:0]          i_data_layer;
  logic [DATA_COUNTER_WIDTH-1:0]   i_data_addr;
  logic [DATA_WIDTH-1:0]           i_data;

  // weight port request
  logic                            i_ram_weight_enable;
  logic                            i_rw_weight_select;
  logic [LAYER_WIDTH-1:0]          i_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr;
  logic [DATA_WIDTH-1:0]           i_weight;

  // data port result
  logic                            o_data_valid;
  logic [LAYER_WIDTH-1:0]          o_data_layer;
  logic [DATA_COUNTER_WIDTH-1:0]   o_data_addr;
  logic [DATA_WIDTH-1:0]           o_data;

  // weight port result
  logic                            o_weight_valid;
  logic [LAYER_WIDTH-1:0]          o_weight_layer;
  logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr;
  logic [DATA_WIDTH-1:0]           o_weight;

  modport master (
    output i_ram_data_enable, i_rw_data_select, i_data_layer, i_data_addr, i_data,
    output i_ram_weight_enable, i_rw_weight_select, i_weight_layer, i_weight_addr, i_weight,
    input  o_data_valid, o_data_layer, o_data_addr, o_data,
    input  o_weight_valid, o_weight_layer, o_weight_addr, o_weight
  );

  modport slave (
    input  i_ram_data_enable, i_rw_data_select, i_data_layer, i_data_addr, i_data,
    input  i_ram_weight_enable, i_rw_weight_select, i_weight_layer, i_weight_addr, i_weight,
    output o_data_valid, o_data_layer, o_data_addr, o_data,
    output o_weight_valid, o_weight_layer, o_weight_addr, o_weight
  );

endinterface

// File: rtl/ann_param_memory.sv
// Activation (data) and weight store for the 3-layer MLP, two independent ports,
// 1-cycle registered reads. Define ANN_MEM_WRITE_ACK_EN to echo writes as well.
module ann_param_memory #(
  parameter int unsigned DATA_WIDTH                    = 32,
  parameter int unsigned LAYER_WIDTH                   = 2,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3
) (
  input logic               clk,
  input logic               rst_n,
  ann_param_memory_if.slave bus
);

  localparam int unsigned IN  = NUMBER_OF_INPUT_NODE;
  localparam int unsigned H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int unsigned H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int unsigned OUT = NUMBER_OF_OUTPUT_NODE;

  localparam int unsigned DATA_COUNTER_WIDTH   = $clog2(H1);
  localparam int unsigned WEIGHT_COUNTER_WIDTH = 11;

  // Both banks are flat RAMs; each layer occupies a contiguous slice at a fixed base.
  localparam int unsigned DATA_DEPTH   = IN + H1 + H2 + OUT;
  localparam int unsigned DIDX_W       = $clog2(DATA_DEPTH);
  localparam int unsigned W1_DEPTH     = H1 * (IN + 1);
  localparam int unsigned W2_DEPTH     = H2 * (H1 + 1);
  localparam int unsigned W3_DEPTH     = OUT * (H2 + 1);
  localparam int unsigned WEIGHT_DEPTH = W1_DEPTH + W2_DEPTH + W3_DEPTH;
  localparam int unsigned WIDX_W       = $clog2(WEIGHT_DEPTH);

`ifdef ANN_MEM_WRITE_ACK_EN
  localparam bit WRITE_ACK = 1'b1;
`else
  localparam bit WRITE_ACK = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] data_ram   [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] weight_ram [WEIGHT_DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  int unsigned       d_depth_c;
  int unsigned       d_base_c;
  logic              d_hit_c;
  logic [DIDX_W-1:0] d_idx_c;
  logic              d_we_c;

  always_comb begin
    d_depth_c = 0;
    d_base_c  = 0;
    case (bus.i_data_layer)
      LAYER_WIDTH'(0): begin d_depth_c = IN;  d_base_c = 0;            end
      LAYER_WIDTH'(1): begin d_depth_c = H1;  d_base_c = IN;           end
      LAYER_WIDTH'(2): begin d_depth_c = H2;  d_base_c = IN + H1;      end
      LAYER_WIDTH'(3): begin d_depth_c = OUT; d_base_c = IN + H1 + H2; end
      default: ;
    endcase
    d_hit_c = (32'(bus.i_data_addr) < d_depth_c);
    d_idx_c = DIDX_W'(d_base_c + 32'(bus.i_data_addr));
    d_we_c  = rst_n && bus.i_ram_data_enable && !bus.i_rw_data_select && d_hit_c;
  end

  int unsigned       w_depth_c;
  int unsigned       w_base_c;
  logic              w_hit_c;
  logic [WIDX_W-1:0] w_idx_c;
  logic              w_we_c;

  // Weight layer 0 has no slice: depth 0 makes every access out of range.
  always_comb begin
    w_depth_c = 0;
    w_base_c  = 0;
    case (bus.i_weight_layer)
      LAYER_WIDTH'(1): begin w_depth_c = W1_DEPTH; w_base_c = 0;                   end
      LAYER_WIDTH'(2): begin w_depth_c = W2_DEPTH; w_base_c = W1_DEPTH;            end
      LAYER_WIDTH'(3): begin w_depth_c = W3_DEPTH; w_base_c = W1_DEPTH + W2_DEPTH; end
      default: ;
    endcase
    w_hit_c = (32'(bus.i_weight_addr) < w_depth_c);
    w_idx_c = WIDX_W'(w_base_c + 32'(bus.i_weight_addr));
    w_we_c  = rst_n && bus.i_ram_weight_enable && !bus.i_rw_weight_select && w_hit_c;
  end

  // ---------------------------------------------------------------------------
  // Storage: never reset, so contents survive rst_n
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (d_we_c) begin
      data_ram[d_idx_c] <= bus.i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_c) begin
      weight_ram[w_idx_c] <= bus.i_weight;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic                            d_valid_q, d_valid_d;
  logic [LAYER_WIDTH-1:0]          d_layer_q, d_layer_d;
  logic [DATA_COUNTER_WIDTH-1:0]   d_addr_q,  d_addr_d;
  logic [DATA_WIDTH-1:0]           d_data_q,  d_data_d;

  logic                            w_valid_q, w_valid_d;
  logic [LAYER_WIDTH-1:0]          w_layer_q, w_layer_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] w_addr_q,  w_addr_d;
  logic [DATA_WIDTH-1:0]           w_data_q,  w_data_d;

  // RAM read happens before the same-edge write lands, giving read-before-write.
  always_comb begin
    d_valid_d = 1'b0;
    d_layer_d = d_layer_q;
    d_addr_d  = d_addr_q;
    d_data_d  = d_data_q;
    if (bus.i_ram_data_enable && (bus.i_rw_data_select || WRITE_ACK)) begin
      d_valid_d = 1'b1;
      d_layer_d = bus.i_data_layer;
      d_addr_d  = bus.i_data_addr;
      if (!d_hit_c) begin
        d_data_d = '0;
      end else if (bus.i_rw_data_select) begin
        d_data_d = data_ram[d_idx_c];
      end else begin
        d_data_d = bus.i_data;
      end
    end
  end

  always_comb begin
    w_valid_d = 1'b0;
    w_layer_d = w_layer_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    if (bus.i_ram_weight_enable && (bus.i_rw_weight_select || WRITE_ACK)) begin
      w_valid_d = 1'b1;
      w_layer_d = bus.i_weight_layer;
      w_addr_d  = bus.i_weight_addr;
      if (!w_hit_c) begin
        w_data_d = '0;
      end else if (bus.i_rw_weight_select) begin
        w_data_d = weight_ram[w_idx_c];
      end else begin
        w_data_d = bus.i_weight;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_valid_q <= 1'b0;
      d_layer_q <= '0;
      d_addr_q  <= '0;
      d_data_q  <= '0;
      w_valid_q <= 1'b0;
      w_layer_q <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_layer_q <= d_layer_d;
      d_addr_q  <= d_addr_d;
      d_data_q  <= d_data_d;
      w_valid_q <= w_valid_d;
      w_layer_q <= w_layer_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

  assign bus.o_data_valid   = d_valid_q;
  assign bus.o_data_layer   = d_layer_q;
  assign bus.o_data_addr    = d_addr_q;
  assign bus.o_data         = d_data_q;
  assign bus.o_weight_valid = w_valid_q;
  assign bus.o_weight_layer = w_layer_q;
  assign bus.o_weight_addr  = w_addr_q;
  assign bus.o_weight       = w_data_q;

endmodule

// File: tb/tb_ann_param_memory.sv
// Self-checking bench for ann_param_memory: directed table, reset sequences and
// randomized traffic against a per-layer array model.
module tb_ann_param_memory;

  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 2;
  localparam int unsigned DCW = 5;
  localparam int unsigned WCW = 11;

`ifdef ANN_MEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk;
  logic rst_n;

  ann_param_memory_if #(
    .DATA_WIDTH(DW), .LAYER_WIDTH(LW),
    .DATA_COUNTER_WIDTH(DCW), .WEIGHT_COUNTER_WIDTH(WCW)
  ) bus ();

  ann_param_memory #(
    .DATA_WIDTH(DW), .LAYER_WIDTH(LW),
    .NUMBER_OF_INPUT_NODE(2), .NUMBER_OF_HIDDEN_NODE_LAYER_1(32),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(32), .NUMBER_OF_OUTPUT_NODE(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one array per layer, indexed directly by node / flat weight index.
  logic [31:0] dmodel [4][32];
  logic [31:0] wmodel [4][2048];

  // Expected result registers (hold values when no new result)
  logic        ed_v, ew_v;
  logic [1:0]  ed_l, ew_l;
  logic [4:0]  ed_a;
  logic [10:0] ew_a;
  logic [31:0] ed_d, ew_d;

  function automatic int unsigned ddepth(input logic [1:0] l);
    case (l)
      2'd0: return 2;
      2'd1: return 32;
      2'd2: return 32;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned wdepth(input logic [1:0] l);
    case (l)
      2'd1: return 32 * (2 + 1);
      2'd2: return 32 * (32 + 1);
      2'd3: return 3 * (32 + 1);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: present both port requests, predict from the model, compare after the edge.
  task automatic cycle(input logic de, input logic drw, input logic [1:0] dl,
                       input logic [4:0] da, input logic [31:0] dwd,
                       input logic we, input logic wrw, input logic [1:0] wl,
                       input logic [10:0] wa, input logic [31:0] wwd);
    bit d_in;
    bit w_in;
    bus.i_ram_data_enable   = de;
    bus.i_rw_data_select    = drw;
    bus.i_data_layer        = dl;
    bus.i_data_addr         = da;
    bus.i_data              = dwd;
    bus.i_ram_weight_enable = we;
    bus.i_rw_weight_select  = wrw;
    bus.i_weight_layer      = wl;
    bus.i_weight_addr       = wa;
    bus.i_weight            = wwd;
    @(posedge clk);
    d_in = (32'(da) < ddepth(dl));
    w_in = (32'(wa) < wdepth(wl));
    if (!rst_n) begin
      ed_v = 1'b0; ed_l = '0; ed_a = '0; ed_d = '0;
      ew_v = 1'b0; ew_l = '0; ew_a = '0; ew_d = '0;
    end else begin
      ed_v = 1'b0;
      if (de && (drw || ACK)) begin
        ed_v = 1'b1; ed_l = dl; ed_a = da;
        ed_d = !d_in ? 32'h0 : (drw ? dmodel[dl][da] : dwd);
      end
      if (de && !drw && d_in) dmodel[dl][da] = dwd;
      ew_v = 1'b0;
      if (we && (wrw || ACK)) begin
        ew_v = 1'b1; ew_l = wl; ew_a = wa;
        ew_d = !w_in ? 32'h0 : (wrw ? wmodel[wl][wa] : wwd);
      end
      if (we && !wrw && w_in) wmodel[wl][wa] = wwd;
    end
    #1;
    chk("o_data_valid",   32'(bus.o_data_valid),   32'(ed_v));
    chk("o_data_layer",   32'(bus.o_data_layer),   32'(ed_l));
    chk("o_data_addr",    32'(bus.o_data_addr),    32'(ed_a));
    chk("o_data",         bus.o_data,              ed_d);
    chk("o_weight_valid", 32'(bus.o_weight_valid), 32'(ew_v));
    chk("o_weight_layer", 32'(bus.o_weight_layer), 32'(ew_l));
    chk("o_weight_addr",  32'(bus.o_weight_addr),  32'(ew_a));
    chk("o_weight",       bus.o_weight,            ew_d);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0, 11'd0, 32'h0);
  endtask

  typedef struct {
    logic        d_en, d_rw;
    logic [1:0]  d_l;
    logic [4:0]  d_a;
    logic [31:0] d_wd;
    logic        w_en, w_rw;
    logic [1:0]  w_l;
    logic [10:0] w_a;
    logic [31:0] w_wd;
    logic        x_dv;
    logic [31:0] x_dd;
    logic        x_wv;
    logic [31:0] x_wd;
  } vec_t;

  function automatic vec_t mk(input logic de, input logic drw, input logic [1:0] dl,
                              input logic [4:0] da, input logic [31:0] dwd,
                              input logic we, input logic wrw, input logic [1:0] wl,
                              input logic [10:0] wa, input logic [31:0] wwd,
                              input logic xdv, input logic [31:0] xdd,
                              input logic xwv, input logic [31:0] xwd);
    vec_t v;
    v.d_en = de; v.d_rw = drw; v.d_l = dl; v.d_a = da; v.d_wd = dwd;
    v.w_en = we; v.w_rw = wrw; v.w_l = wl; v.w_a = wa; v.w_wd = wwd;
    v.x_dv = xdv; v.x_dd = xdd; v.x_wv = xwv; v.x_wd = xwd;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0]  rl;
    logic [4:0]  ra;
    logic [10:0] rwa;
    int unsigned dep;

    //             de   drw  dl    da     dwd            we   wrw  wl    wa        wwd            xdv  xdd            xwv  xwd
    vecs[0]  = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b0,2'd2,11'd1055,32'h40490FDB, 1'b0,32'h0,        ACK, 32'h40490FDB);
    vecs[1]  = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b0,2'd3,11'd98,  32'hBF000000, 1'b0,32'h0,        ACK, 32'hBF000000);
    vecs[2]  = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b1,2'd2,11'd1055,32'h0,        1'b0,32'h0,        1'b1,32'h40490FDB);
    vecs[3]  = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b1,2'd3,11'd98,  32'h0,        1'b0,32'h0,        1'b1,32'hBF000000);
    vecs[4]  = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b1,2'd3,11'd99,  32'h0,        1'b0,32'h0,        1'b1,32'h0);
    vecs[5]  = mk(1'b1,1'b0,2'd3,5'd2, 32'h41200000, 1'b1,1'b1,2'd1,11'd5,   32'h0,        ACK, 32'h41200000, 1'b1,32'h3F800005);
    vecs[6]  = mk(1'b1,1'b1,2'd3,5'd2, 32'h0,        1'b0,1'b0,2'd0,11'd0,   32'h0,        1'b1,32'h41200000, 1'b0,32'h0);
    vecs[7]  = mk(1'b1,1'b0,2'd1,5'd7, 32'hAAAA0007, 1'b0,1'b0,2'd0,11'd0,   32'h0,        ACK, 32'hAAAA0007, 1'b0,32'h0);
    vecs[8]  = mk(1'b1,1'b0,2'd1,5'd7, 32'hBBBB0007, 1'b0,1'b0,2'd0,11'd0,   32'h0,        ACK, 32'hBBBB0007, 1'b0,32'h0);
    vecs[9]  = mk(1'b1,1'b1,2'd1,5'd7, 32'h0,        1'b0,1'b0,2'd0,11'd0,   32'h0,        1'b1,32'hBBBB0007, 1'b0,32'h0);
    vecs[10] = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b0,2'd0,11'd4,   32'hDEADBEEF, 1'b0,32'h0,        ACK, 32'h0);
    vecs[11] = mk(1'b0,1'b0,2'd0,5'd0, 32'h0,        1'b1,1'b1,2'd0,11'd4,   32'h0,        1'b0,32'h0,        1'b1,32'h0);
    vecs[12] = mk(1'b1,1'b1,2'd0,5'd2, 32'h0,        1'b1,1'b1,2'd1,11'd95,  32'h0,        1'b1,32'h0,        1'b1,32'h3F80005F);
    vecs[13] = mk(1'b1,1'b0,2'd3,5'd3, 32'h12121212, 1'b0,1'b0,2'd0,11'd0,   32'h0,        ACK, 32'h0,        1'b0,32'h0);
    vecs[14] = mk(1'b1,1'b1,2'd3,5'd3, 32'h0,        1'b0,1'b0,2'd0,11'd0,   32'h0,        1'b1,32'h0,        1'b0,32'h0);

    // Reset state: all outputs zero while rst_n is low
    rst_n = 1'b0;
    repeat (3) idle();
    rst_n = 1'b1;
    idle();

    // Weight layer 1 load, then back-to-back readback
    for (int a = 0; a < 96; a++)
      cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd1, 11'(a), 32'h3F800000 + 32'(a));
    for (int a = 0; a < 96; a++) begin
      cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'd1, 11'(a), 32'h0);
      chk("l1_readback_valid", 32'(bus.o_weight_valid), 32'd1);
      chk("l1_readback_data",  bus.o_weight, 32'h3F800000 + 32'(a));
    end

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].d_en, vecs[i].d_rw, vecs[i].d_l, vecs[i].d_a, vecs[i].d_wd,
            vecs[i].w_en, vecs[i].w_rw, vecs[i].w_l, vecs[i].w_a, vecs[i].w_wd);
      chk($sformatf("vec%0d d_valid", i), 32'(bus.o_data_valid),   32'(vecs[i].x_dv));
      chk($sformatf("vec%0d w_valid", i), 32'(bus.o_weight_valid), 32'(vecs[i].x_wv));
      if (vecs[i].x_dv) chk($sformatf("vec%0d d_data", i), bus.o_data,   vecs[i].x_dd);
      if (vecs[i].x_wv) chk($sformatf("vec%0d w_data", i), bus.o_weight, vecs[i].x_wd);
    end

    // Reset mid-read; writes presented during reset are dropped
    cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b1, 2'd1, 11'd10, 32'h0);
    chk("pre_reset_read", bus.o_weight, 32'h3F80000A);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 2'd1, 5'd7, 32'h0, 1'b1, 1'b1, 2'd1, 11'd11, 32'h0);
    chk("reset_w_valid", 32'(bus.o_weight_valid), 32'd0);
    chk("reset_w_data",  bus.o_weight, 32'h0);
    chk("reset_d_valid", 32'(bus.o_data_valid), 32'd0);
    cycle(1'b1, 1'b0, 2'd1, 5'd7, 32'h0BADF00D, 1'b1, 1'b0, 2'd1, 11'd10, 32'hFFFFFFFF);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 2'd1, 5'd7, 32'h0, 1'b1, 1'b1, 2'd1, 11'd10, 32'h0);
    chk("post_reset_w", bus.o_weight, 32'h3F80000A);
    chk("post_reset_d", bus.o_data,   32'hBBBB0007);

    // Write acknowledge (or its absence in the default build)
    cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd1, 11'd3, 32'h12345678);
    chk("ack_w_valid", 32'(bus.o_weight_valid), 32'(ACK));
    if (ACK) begin
      chk("ack_w_addr", 32'(bus.o_weight_addr), 32'd3);
      chk("ack_w_data", bus.o_weight, 32'h12345678);
    end
    idle();

    // Fill the rest of both banks so every in-range location is known
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < int'(ddepth(2'(l))); a++)
        cycle(1'b1, 1'b0, 2'(l), 5'(a), $urandom, 1'b0, 1'b0, 2'd0, 11'd0, 32'h0);
    for (int l = 2; l < 4; l++)
      for (int a = 0; a < int'(wdepth(2'(l))); a++)
        cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b0, 2'(l), 11'(a), $urandom);

    // Randomized concurrent traffic on both ports
    for (int n = 0; n < 500; n++) begin
      logic de, drw, we, wrw;
      logic [1:0] wl;
      de  = 1'($urandom_range(0, 3) != 0);
      drw = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 3) != 0);
      wrw = 1'($urandom_range(0, 1));
      rl  = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, ddepth(rl) - 1)) : 5'($urandom);
      wl  = 2'($urandom_range(0, 3));
      dep = wdepth(wl);
      rwa = (dep != 0 && $urandom_range(0, 3) != 0) ? 11'($urandom_range(0, dep - 1)) : 11'($urandom);
      cycle(de, drw, rl, ra, $urandom, we, wrw, wl, rwa, $urandom);
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
